// File: rtl/serial_ext_pkg.sv
// serial_ext shared definitions: register map,
// STATUS bit layout and the transmit FSM states.
package serial_ext_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_BUSY  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_FULL  = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   // a zero divisor would never end a bit, so run it as one clock
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO
// is accepted when a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     r,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign rdata = mem_q[rd_q];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // next pointers and occupancy; flush wins over everything
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // pointer and count registers
   always_ff @(posedge clk) begin
      if (r) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (do_push && !flush && !r) begin
         mem_q[wr_q] <= wdata;
      end
   end

endmodule

// File: rtl/serial_ext.sv
// Transmit-only 8N1 serial console on the expansion port:
// register decode, FIFO, divisor and the tx FSM.
module serial_ext
   import serial_ext_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
   input  logic        clk,
   input  logic        r,
   inout  wire  [15:0] bus,
   input  logic [23:0] addro,
   input  logic        epwe,
   input  logic        epoe,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e   state_q, state_d;
   logic        tx_q, tx_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] div_q, div_d;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] div_reg_q, div_reg_d;
   logic        ovf_q, ovf_d;

   logic [1:0]    addr;
   logic          wr_data;
   logic          wr_div;
   logic          flush;
   logic          rd_status;
   logic          pop;
   logic          bit_end;
   logic          fifo_avail;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [7:0]    cnt8;
   logic [15:0]   status;
   logic [15:0]   rdata;
   logic          unused_addr;

   assign addr        = addro[1:0];
   assign unused_addr = ^addro[23:2];

   assign wr_data   = epwe && (addr == REG_DATA);
   assign wr_div    = epwe && (addr == REG_DIV);
   assign flush     = epwe && (addr == REG_CTRL) && bus[0];
   assign rd_status = epoe && (addr == REG_STATUS);

   // a flushing edge must not also start a frame
   assign fifo_avail = !fifo_empty && !flush;
   assign bit_end    = (clk_cnt_q == div_q - 16'd1);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .r     (r),
      .push  (wr_data),
      .pop   (pop),
      .flush (flush),
      .wdata (bus[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign cnt8 = 8'(fifo_count);

   // STATUS word assembly
   always_comb begin
      status               = '0;
      status[ST_CNT +: 8]  = cnt8;
      status[ST_OVF]       = ovf_q;
      status[ST_FULL]      = fifo_full;
      status[ST_EMPTY]     = fifo_empty;
      status[ST_BUSY]      = (state_q != TX_IDLE);
   end

   // read mux, shows state from before the edge
   always_comb begin
      rdata = '0;
      unique case (addr)
         REG_STATUS: rdata = status;
         REG_DIV:    rdata = div_reg_q;
         default:    rdata = '0;
      endcase
   end

   assign bus = epoe ? rdata : 'z;
   assign tx  = tx_q;

   // divisor register and sticky overflow flag
   always_comb begin
      div_reg_d = wr_div ? bus : div_reg_q;
      ovf_d     = ovf_q;
      if (rd_status) ovf_d = 1'b0;
      if (wr_data && fifo_full && !pop) ovf_d = 1'b1;
   end

   // tx FSM: bit timing, shifting and FIFO pops
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      shift_d   = shift_q;
      div_d     = div_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      pop       = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (fifo_avail) begin
               pop       = 1'b1;
               shift_d   = fifo_rdata;
               div_d     = eff_div(div_reg_q);
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = TX_START;
               tx_d      = 1'b0;
            end
         end
         TX_START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = TX_DATA;
               tx_d      = shift_q[0];
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = TX_STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (fifo_avail) begin
                  pop       = 1'b1;
                  shift_d   = fifo_rdata;
                  div_d     = eff_div(div_reg_q);
                  bit_cnt_d = '0;
                  state_d   = TX_START;
                  tx_d      = 1'b0;
               end else begin
                  state_d = TX_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // all block state, reset overrides any write
   always_ff @(posedge clk) begin
      if (r) begin
         state_q   <= TX_IDLE;
         tx_q      <= 1'b1;
         shift_q   <= '0;
         div_q     <= 16'd1;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         div_reg_q <= DEFAULT_DIV;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         shift_q   <= shift_d;
         div_q     <= div_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         div_reg_q <= div_reg_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_serial_ext.sv
// Bench for serial_ext: register table, tx frame
// scoreboard and multi-cycle corner sequences.
module tb_serial_ext;
   import serial_ext_pkg::*;

   logic        clk;
   logic        r;
   logic        epwe;
   logic        epoe;
   logic [23:0] addro;
   wire  [15:0] bus;
   logic        tx;
   logic        drv_en;
   logic [15:0] drv_val;

   assign bus = drv_en ? drv_val : 'z;

   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (bus[g]);
   end

   serial_ext #(
      .FIFO_DEPTH  (16),
      .DEFAULT_DIV (16'd16)
   ) dut (
      .clk   (clk),
      .r     (r),
      .bus   (bus),
      .addro (addro),
      .epwe  (epwe),
      .epoe  (epoe),
      .tx    (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      int         div;
   } frm_t;

   typedef struct {
      logic        we;
      logic        oe;
      logic [1:0]  a;
      logic [15:0] d;
      logic [15:0] exp;
      string       nm;
   } vec_t;

   frm_t sb[$];
   vec_t tbl[12];
   int   errors;
   int   checks;
   int   cur_div;

   int         m_p;
   int         m_b;
   int         m_ph;
   int         m_div;
   bit         m_act;
   bit         m_ok;
   bit         m_abort;
   logic       m_first;
   logic [7:0] m_byte;
   frm_t       m_exp;

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_write(input logic [1:0] a, input logic [15:0] d);
      addro   = {22'($urandom), a};
      drv_val = d;
      drv_en  = 1'b1;
      epwe    = 1'b1;
      @(negedge clk);
      epwe    = 1'b0;
      drv_en  = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      sb.push_back('{b, cur_div});
      do_write(REG_DATA, {8'h00, b});
   endtask

   task automatic peek(input logic oe, input logic [1:0] a,
                       output logic [15:0] v);
      epoe  = oe;
      addro = {22'($urandom), a};
      #1;
      v     = bus;
      epoe  = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a, output logic [15:0] v);
      epoe  = 1'b1;
      addro = {22'($urandom), a};
      #1;
      v = bus;
      @(negedge clk);
      epoe = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string nm);
      logic [15:0] v;
      int n;
      n = 0;
      peek(1'b1, REG_STATUS, v);
      while (v !== 16'h0002 && n < maxc) begin
         @(negedge clk);
         peek(1'b1, REG_STATUS, v);
         n++;
      end
      check(nm, v, 16'h0002);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      bit saw_low;
      errors  = 0;
      checks  = 0;
      cur_div = 16;
      m_act   = 1'b0;
      m_abort = 1'b0;
      r       = 1'b1;
      epwe    = 1'b0;
      epoe    = 1'b0;
      addro   = '0;
      drv_en  = 1'b0;
      drv_val = '0;

      tbl[0]  = '{1'b0, 1'b1, REG_STATUS, 16'h0000, 16'h0002, "rst_status"};
      tbl[1]  = '{1'b0, 1'b1, REG_DIV,    16'h0000, 16'h0010, "rst_div"};
      tbl[2]  = '{1'b0, 1'b1, REG_DATA,   16'h0000, 16'h0000, "rd_data"};
      tbl[3]  = '{1'b0, 1'b1, REG_CTRL,   16'h0000, 16'h0000, "rd_ctrl"};
      tbl[4]  = '{1'b0, 1'b0, REG_DIV,    16'h0000, 16'hffff, "hiz_div"};
      tbl[5]  = '{1'b1, 1'b0, REG_DIV,    16'h1234, 16'h0000, "wr_div"};
      tbl[6]  = '{1'b0, 1'b1, REG_DIV,    16'h0000, 16'h1234, "rd_div"};
      tbl[7]  = '{1'b1, 1'b0, REG_DIV,    16'h0000, 16'h0000, "wr_div0"};
      tbl[8]  = '{1'b0, 1'b1, REG_DIV,    16'h0000, 16'h0000, "rd_div0"};
      tbl[9]  = '{1'b1, 1'b0, REG_CTRL,   16'h0001, 16'h0000, "flush0"};
      tbl[10] = '{1'b0, 1'b1, REG_STATUS, 16'h0000, 16'h0002, "st_idle"};
      tbl[11] = '{1'b0, 1'b0, REG_STATUS, 16'h0000, 16'hffff, "hiz_st"};

      fork
         forever begin
            @(negedge clk);
            if (m_abort) begin
               m_act   = 1'b0;
               m_abort = 1'b0;
            end else begin
               if (!m_act) begin
                  if (tx == 1'b0) begin
                     m_act  = 1'b1;
                     m_p    = 0;
                     m_ok   = 1'b1;
                     m_byte = '0;
                     if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexp_frame: got start bit want idle");
                        m_div = cur_div;
                     end else begin
                        m_div = sb[0].div;
                     end
                  end
               end else begin
                  m_p++;
               end
               if (m_act) begin
                  m_b  = m_p / m_div;
                  m_ph = m_p % m_div;
                  if (m_ph == 0) begin
                     m_first = tx;
                     if (m_b >= 1 && m_b <= 8) m_byte = {tx, m_byte[7:1]};
                     else if (m_b == 0 && tx !== 1'b0) m_ok = 1'b0;
                     else if (m_b == 9 && tx !== 1'b1) m_ok = 1'b0;
                  end
                  if (m_ph == m_div - 1) begin
                     if (tx !== m_first) m_ok = 1'b0;
                     if (m_b == 9) begin
                        m_act = 1'b0;
                        if (sb.size() > 0) begin
                           m_exp = sb.pop_front();
                           check("frame", {7'd0, m_ok, m_byte},
                                 {8'h01, m_exp.b});
                        end
                     end
                  end
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      r = 1'b0;
      check("rst_tx", {15'd0, tx}, 16'h0001);

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].we) begin
            do_write(tbl[i].a, tbl[i].d);
         end else begin
            peek(tbl[i].oe, tbl[i].a, v);
            check(tbl[i].nm, v, tbl[i].exp);
            @(negedge clk);
         end
      end

      // DIV=0 runs as one clock per bit
      cur_div = 1;
      send(8'h81);
      wait_idle(100, "div0_idle");

      // single frame, DIV=4
      do_write(REG_DIV, 16'd4);
      cur_div = 4;
      send(8'h55);
      check("lat_pre", {15'd0, tx}, 16'h0001);
      @(negedge clk);
      check("lat_start", {15'd0, tx}, 16'h0000);
      peek(1'b1, REG_STATUS, v);
      check("busy_start", v, 16'h0003);
      repeat (39) @(negedge clk);
      peek(1'b1, REG_STATUS, v);
      check("busy_end", v, 16'h0003);
      @(negedge clk);
      peek(1'b1, REG_STATUS, v);
      check("idle_40", v, 16'h0002);

      // back-to-back frames, DIV=1
      do_write(REG_DIV, 16'd1);
      cur_div = 1;
      send(8'h41);
      send(8'h42);
      peek(1'b1, REG_STATUS, v);
      check("b2b_cnt", v, 16'h0101);
      repeat (9) @(negedge clk);
      peek(1'b1, REG_STATUS, v);
      check("b2b_cnt2", v, 16'h0101);
      @(negedge clk);
      peek(1'b1, REG_STATUS, v);
      check("b2b_pop2", v, 16'h0003);
      repeat (9) @(negedge clk);
      peek(1'b1, REG_STATUS, v);
      check("b2b_busy", v, 16'h0003);
      @(negedge clk);
      peek(1'b1, REG_STATUS, v);
      check("b2b_idle", v, 16'h0002);

      // fill, overflow, clear-on-read, push+pop at full
      do_write(REG_DIV, 16'd4);
      cur_div = 4;
      for (int i = 0; i < 17; i++) send(8'(8'hA0 + i));
      do_write(REG_DATA, 16'h00EE);
      peek(1'b1, REG_STATUS, v);
      check("ovf_status", v, 16'h100D);
      do_read(REG_STATUS, v);
      check("ovf_read", v, 16'h100D);
      peek(1'b1, REG_STATUS, v);
      check("ovf_clr", v, 16'h1005);
      repeat (22) @(negedge clk);
      send(8'h5A);
      peek(1'b1, REG_STATUS, v);
      check("full_pushpop", v, 16'h1005);
      wait_idle(900, "fill_drain");
      check("fill_sb", 16'(sb.size()), 16'd0);

      // flush mid-frame with 5 bytes queued
      for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
      peek(1'b1, REG_STATUS, v);
      check("fl_cnt", v, 16'h0501);
      do_write(REG_CTRL, 16'h0001);
      while (sb.size() > 1) void'(sb.pop_back());
      peek(1'b1, REG_STATUS, v);
      check("fl_empty", v, 16'h0003);
      wait_idle(60, "fl_idle");
      saw_low = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (tx == 1'b0) saw_low = 1'b1;
      end
      check("fl_nostart", {15'd0, saw_low}, 16'h0000);
      check("fl_sb", 16'(sb.size()), 16'd0);

      // reset during data bit 3
      send(8'hC3);
      repeat (18) @(negedge clk);
      check("pre_rst_bit3", {15'd0, tx}, 16'h0000);
      r       = 1'b1;
      m_abort = 1'b1;
      sb.delete();
      @(negedge clk);
      r = 1'b0;
      check("rst_mid_tx", {15'd0, tx}, 16'h0001);
      peek(1'b1, REG_STATUS, v);
      check("rst_mid_st", v, 16'h0002);
      peek(1'b1, REG_DIV, v);
      check("rst_mid_div", v, 16'h0010);
      peek(1'b0, REG_DIV, v);
      check("rst_mid_hiz", v, 16'hffff);
      cur_div = 16;
      send(8'h3C);
      wait_idle(250, "rst_frame_idle");
      check("rst_sb", 16'(sb.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_ext.md
Name: serial_ext

Overview:
Expansion-port responder that gives the CPU a transmit-only serial console. It sits on the shared 16-bit bus and 24-bit addro alongside the drive and GPU extensions, wired to port C (epcwe/epcoe).
- CPU writes bytes into a transmit FIFO through port strobes.
- The block serialises the bytes as 8N1 frames on a tx pin.
- The CPU reads a status word back over the same bus.

Parameters:
FIFO_DEPTH, 16, transmit FIFO entries; power of two, 2..256.
DEFAULT_DIV, 16, clocks per serial bit after reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
r  input  1  reset; synchronous, active-high.
bus  inout  16  shared data bus; driven only while epoe=1, otherwise high-Z.
addro  input  24  address; only addro[1:0] decoded, bits [23:2] ignored.
epwe  input  1  port write enable; sampled at rising edge.
epoe  input  1  port output enable; read data driven combinationally.
tx  output  1  serial line; idle high, registered.

Behaviour:
- Register map (addro[1:0]):
  - 0 DATA: write enqueues bus[7:0]; read returns 16'h0000.
  - 1 STATUS: read-only.
  - 2 DIV: write sets bus[15:0]; read returns current DIV.
  - 3 CTRL: write with bus[0]=1 flushes the FIFO; read returns 0.
- STATUS = {count[7:0], 4'b0, overflow, full, empty, busy}.
  - count: FIFO occupancy.
  - busy: FSM not IDLE.
- Reset (r=1 at an edge): tx=1, FSM=IDLE, FIFO empty, count=0, overflow=0, DIV=DEFAULT_DIV, bit/clock counters=0. Reset overrides any concurrent write. Reset mid-frame aborts the frame; tx=1 after that edge.
- Bus:
  - With epoe=1, bus = selected register value (pre-edge state).
  - With epoe=0, bus = 'z.
  - epwe and epoe both high: write takes effect at the edge, and the read shows the old value in that cycle.
- Write to DATA when full: byte dropped, overflow set (sticky).
- Reading STATUS (epoe=1, addr=1, sampled at edge) clears overflow at that edge. If an overflowing write occurs on the same edge, overflow stays set.
- Flush: empties the FIFO in one edge; the frame in progress completes. Flush and a DATA write cannot coincide (distinct addresses).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the byte into the shift register, latch the divisor (DIV==0 treated as 1), go to START, tx<=0.
  - START: after div clocks, go to DATA, tx<=bit0.
  - DATA: each div clocks, shift (LSB first). After bit7 has held for div clocks, go to STOP, tx<=1.
  - STOP: after div clocks, go to IDLE.
- Each bit holds exactly div cycles, so a frame is 10*div cycles.
- Back-to-back frames:
  - Leaving STOP with the FIFO non-empty pops directly into START on the same edge, with no idle cycle.
  - Leaving STOP with the FIFO empty goes to IDLE, tx stays 1.
- Latency: byte written at edge N into an empty FIFO in IDLE → pop at edge N+1 → tx low from edge N+1.
- A DIV write mid-frame affects the next frame only.
- Simultaneous push and pop with the FIFO full: the pop frees a slot, the push is accepted, and overflow is not set.
- count is always the true occupancy and never exceeds FIFO_DEPTH.

Decomposition:
- Package serial_ext_pkg holds:
  - register offset constants (REG_DATA, REG_STATUS, REG_DIV, REG_CTRL);
  - the STATUS bit-position constants;
  - the tx FSM state enum.
- One sub-module, sync_fifo (parameterised width/depth), provides:
  - push/pop/flush inputs;
  - full/empty/count outputs;
  - first-word data out;
  - simultaneous push+pop at full is legal.
- serial_ext holds the decode, the registers and the tx FSM.

Test Plan:
- Reset then read STATUS → bus=16'h0002 (empty); read DIV → 16'd16; tx=1.
- Write DIV=4, write DATA=0x55 → tx=0 for 4 clocks from the next edge, then 1,0,1,0,1,0,1,0 (4 clocks each), then 1 for 4 clocks; busy=1 during the frame, and IDLE at 40 clocks after the pop.
- DIV=1, write 0x41 and 0x42 back-to-back → two frames with stop bit followed directly by start bit, 20 clocks total; STATUS count reads 1 between the two pops.
- Fill 16 bytes while tx is busy, write a 17th → full=1, overflow=1, count=16. Reading STATUS returns 16'h100D and clears overflow on the next read (16'h1005).
- Mid-frame CTRL write bus[0]=1 with 5 bytes queued → count=0 next cycle, the current frame finishes, no further start bit.
- Assert r for one edge during DATA bit 3 → tx=1, STATUS=16'h0002, DIV=16 afterward; bus=z whenever epoe=0.
